// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the E-stage multiply/divide unit and the hazard unit:
// MD operation encoding, default latencies, the HI/LO pair type and the
// single-cycle arithmetic helpers used to form the full result at issue time.
// ----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_hilo_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // 32x32 -> 64 product. Operands are extended to 64 bits first, so the low
    // 64 bits of the product are correct for both signed and unsigned forms.
    function automatic md_hilo_t md_mul(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        is_signed);
        logic [63:0] a_x;
        logic [63:0] b_x;
        logic [63:0] p;
        md_hilo_t    res;
        a_x = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_x = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        p   = a_x * b_x;
        res.hi = p[63:32];
        res.lo = p[31:0];
        return res;
    endfunction

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case. A zero divisor is
    // replaced by 1 only to keep the datapath free of X; the caller discards
    // the result in that case.
    function automatic md_hilo_t md_div(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        is_signed);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        md_hilo_t    res;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;
        end
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        res.lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res.hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        return res;
    endfunction

endpackage

// File: rtl/md_if.sv
// ----------------------------------------------------------------------------
// md_if
// E-stage <-> multiply/divide unit connection.
//   md_en      E-stage instruction valid
//   md_op      MD operation (md_op_e encoding)
//   rs_val     operand A (forwarded rs)
//   rt_val     operand B (forwarded rt)
//   busy       multi-cycle operation in progress
//   md_result  HI for mfhi, LO for mflo, else 0
//   hi_out     current HI
//   lo_out     current LO
// master = E-stage side, slave = mult_div_unit.
// ----------------------------------------------------------------------------
interface md_if;
    logic        md_en;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] md_result;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output md_en, md_op, rs_val, rt_val,
        input  busy, md_result, hi_out, lo_out
    );

    modport slave (
        input  md_en, md_op, rs_val, rt_val,
        output busy, md_result, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit in the E stage. Owns HI/LO and executes
// mult/multu/div/divu/mthi/mtlo; provides the mfhi/mflo read value.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears HI/LO, busy, counter and any
//          pending result
//   md     md_if.slave (md_en, md_op, rs_val, rt_val in;
//          busy, md_result, hi_out, lo_out out)
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no operation in flight; accepts starts and mthi/mtlo
// ST_BUSY  | result held in hi_tmp/lo_tmp, counter running down to commit
//
// The full result is formed in the issue cycle; the counter only models the
// pipeline-visible latency. Both latencies must be at least 1.
// ----------------------------------------------------------------------------
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        hi_tmp_q;
    logic [31:0]        lo_tmp_q;
    logic               commit_q;
    logic               busy_q;

    md_hilo_t           res_d;
    logic               commit_d;
    logic [CNT_W-1:0]   lat_d;
    logic               start;

    assign start = md.md_en && is_md_start(md.md_op);

    // Result, latency and commit flag for a start presented this cycle.
    always_comb begin
        res_d    = '0;
        commit_d = 1'b1;
        lat_d    = CNT_W'(MULT_LAT);
        case (md.md_op)
            MD_MULT:  res_d = md_mul(md.rs_val, md.rt_val, 1'b1);
            MD_MULTU: res_d = md_mul(md.rs_val, md.rt_val, 1'b0);
            MD_DIV: begin
                res_d    = md_div(md.rs_val, md.rt_val, 1'b1);
                commit_d = (md.rt_val != 32'd0);
                lat_d    = CNT_W'(DIV_LAT);
            end
            MD_DIVU: begin
                res_d    = md_div(md.rs_val, md.rt_val, 1'b0);
                commit_d = (md.rt_val != 32'd0);
                lat_d    = CNT_W'(DIV_LAT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hi_tmp_q <= res_d.hi;
                        lo_tmp_q <= res_d.lo;
                        commit_q <= commit_d;
                        cnt_q    <= lat_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_BUSY;
                    end else if (md.md_en && (md.md_op == MD_MTHI)) begin
                        hi_q <= md.rs_val;
                    end else if (md.md_en && (md.md_op == MD_MTLO)) begin
                        lo_q <= md.rs_val;
                    end
                end
                ST_BUSY: begin
                    // Everything presented while busy is dropped; the hazard
                    // unit normally prevents it from arriving at all.
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (commit_q) begin
                            hi_q <= hi_tmp_q;
                            lo_q <= lo_tmp_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read path is combinational on the current HI/LO; while busy it shows the
    // pre-operation values.
    always_comb begin
        md.md_result = 32'd0;
        if (md.md_op == MD_MFHI) begin
            md.md_result = hi_q;
        end else if (md.md_op == MD_MFLO) begin
            md.md_result = lo_q;
        end
    end

    assign md.busy   = busy_q;
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk;
    logic reset;

    md_if u_if ();

    mult_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO plus a pending result that lands on
    // an absolute edge number.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_active, m_pwr;
    int          m_edge, m_done;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic en, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp;
        logic [63:0] up;
        m_edge++;
        if (m_active) begin
            if (m_edge == m_done) begin
                if (m_pwr) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
                m_active = 1'b0;
            end
        end else if (en) begin
            sa = $signed(a);
            sb = $signed(b);
            case (op)
                MD_MULT: begin
                    sp = sa * sb;
                    {m_phi, m_plo} = sp;
                    m_pwr = 1'b1; m_active = 1'b1; m_done = m_edge + MULT_LAT;
                end
                MD_MULTU: begin
                    up = {32'd0, a} * {32'd0, b};
                    {m_phi, m_plo} = up;
                    m_pwr = 1'b1; m_active = 1'b1; m_done = m_edge + MULT_LAT;
                end
                MD_DIV: begin
                    m_pwr = (b != 0);
                    if (b != 0) begin
                        m_plo = 32'(sa / sb);
                        m_phi = 32'(sa % sb);
                    end
                    m_active = 1'b1; m_done = m_edge + DIV_LAT;
                end
                MD_DIVU: begin
                    m_pwr = (b != 0);
                    if (b != 0) begin
                        m_plo = a / b;
                        m_phi = a % b;
                    end
                    m_active = 1'b1; m_done = m_edge + DIV_LAT;
                end
                MD_MTHI: m_hi = a;
                MD_MTLO: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive at the falling edge, check the read path before
    // the rising edge, check registered state at the next falling edge.
    task automatic step(input logic en, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        u_if.md_en  = en;
        u_if.md_op  = op;
        u_if.rs_val = a;
        u_if.rt_val = b;
        #1;
        exp_r = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
        if (en || (op != MD_MFHI && op != MD_MFLO))
            chk("md_result", {32'd0, u_if.md_result}, {32'd0, exp_r});
        model_edge(en, op, a, b);
        @(negedge clk);
        chk("busy", {63'd0, u_if.busy}, {63'd0, m_active});
        chk("hi", {32'd0, u_if.hi_out}, {32'd0, m_hi});
        chk("lo", {32'd0, u_if.lo_out}, {32'd0, m_lo});
    endtask

    task automatic run_to_idle(output int n);
        int guard;
        n = 0;
        guard = 0;
        while (u_if.busy && guard < 40) begin
            step(1'b1, MD_NONE, 32'd0, 32'd0);
            if (u_if.busy) n++;
            guard++;
        end
        if (guard >= 40) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int n);
        step(1'b1, op, a, b);
        n = u_if.busy ? 1 : 0;
    endtask

    initial begin
        int n, k;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        ren;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MULT_LAT};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MULT_LAT};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DIV_LAT};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_LAT};

        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
        m_active = 0; m_pwr = 0; m_edge = 0; m_done = 0;

        reset = 1'b1;
        u_if.md_en = 1'b0; u_if.md_op = MD_NONE; u_if.rs_val = 0; u_if.rt_val = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, u_if.busy}, 64'd0);
        chk("rst_hi", {32'd0, u_if.hi_out}, 64'd0);
        chk("rst_lo", {32'd0, u_if.lo_out}, 64'd0);
        u_if.md_op = MD_MFLO; #1;
        chk("rst_mflo", {32'd0, u_if.md_result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors: latency, final HI/LO and mflo readback.
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            run_to_idle(k);
            chk($sformatf("vec%0d_lat", i), 64'(n + k), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_hi", i), {32'd0, u_if.hi_out}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, u_if.lo_out}, {32'd0, vecs[i].lo});
            u_if.md_op = MD_MFLO; #1;
            chk($sformatf("vec%0d_mflo", i), {32'd0, u_if.md_result}, {32'd0, vecs[i].lo});
            step(1'b1, MD_NONE, 0, 0);
        end

        // Divide by zero keeps prior HI/LO but still takes the full latency.
        step(1'b1, MD_MTHI, 32'h11, 0);
        step(1'b1, MD_MTLO, 32'h22, 0);
        start_op(MD_DIVU, 32'd7, 32'd0, n);
        run_to_idle(k);
        chk("dz_lat", 64'(n + k), 64'(DIV_LAT));
        chk("dz_hi", {32'd0, u_if.hi_out}, 64'h11);
        chk("dz_lo", {32'd0, u_if.lo_out}, 64'h22);

        // MTHI then MFHI; no busy.
        step(1'b1, MD_MTHI, 32'hDEADBEEF, 0);
        chk("mthi_busy", {63'd0, u_if.busy}, 64'd0);
        u_if.md_op = MD_MFHI; #1;
        chk("mfhi", {32'd0, u_if.md_result}, 64'hDEADBEEF);
        step(1'b1, MD_MFHI, 0, 0);

        // MTLO during a divide is dropped.
        start_op(MD_DIV, 32'd100, 32'd7, n);
        step(1'b1, MD_MTLO, 32'h5555, 0);
        chk("mtlo_busy_lo", {32'd0, u_if.lo_out}, 64'hDEADBEEF & 64'h0 | {32'd0, m_lo});
        run_to_idle(k);
        chk("mtlo_div_lo", {32'd0, u_if.lo_out}, 64'd14);
        chk("mtlo_div_hi", {32'd0, u_if.hi_out}, 64'd2);

        // MULT in cycle 2 of a divide is ignored; divide completes on time.
        step(1'b1, MD_MTHI, 32'h0, 0);
        start_op(MD_DIV, 32'd200, 32'd7, n);
        step(1'b1, MD_NONE, 0, 0);
        if (u_if.busy) n++;
        step(1'b1, MD_MULT, 32'd3, 32'd4);
        if (u_if.busy) n++;
        run_to_idle(k);
        chk("ign_lat", 64'(n + k), 64'(DIV_LAT));
        chk("ign_hi", {32'd0, u_if.hi_out}, 64'd4);
        chk("ign_lo", {32'd0, u_if.lo_out}, 64'd28);

        // Asynchronous reset in cycle 3 of a multiply.
        step(1'b1, MD_MTHI, 32'h1234, 0);
        step(1'b1, MD_MTLO, 32'h5678, 0);
        start_op(MD_MULT, 32'd3, 32'd4, n);
        step(1'b1, MD_NONE, 0, 0);
        step(1'b1, MD_MFHI, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, u_if.busy}, 64'd0);
        chk("arst_hi", {32'd0, u_if.hi_out}, 64'd0);
        chk("arst_lo", {32'd0, u_if.lo_out}, 64'd0);
        chk("arst_mfhi", {32'd0, u_if.md_result}, 64'd0);
        m_hi = 0; m_lo = 0; m_active = 0; m_pwr = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) step(1'b1, MD_NONE, 0, 0);
        chk("arst_after_hi", {32'd0, u_if.hi_out}, 64'd0);
        chk("arst_after_lo", {32'd0, u_if.lo_out}, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 8));
            ren = ($urandom_range(0, 7) != 0);
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
            step(ren, rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
